normal_word_feeder: RTL and testbench
=====================================

// Module: normal_word_feeder
// PURPOSE
//   Transmit side of the normal-word interface consumed by round_block.
//   Reads the normal polynomial from word RAM and issues one word per handshake.
//   Sends the first PRELOAD_COUNT words as add-only (only_add=1), then the rest
//   as add+process, then tail_words zero words to flush the low-word window.
//   Sits between the polynomial RAM and round_block.
// PARAMETERS
//   WORD_WIDTH         32   width of one normal polynomial word
//   ADDR_WIDTH         10   word RAM address width
//   NORMAL_WORD_COUNT  553  real words read from RAM (indices 0..552)
//   PRELOAD_COUNT      1    leading words sent with only_add=1 (must be < NORMAL_WORD_COUNT)
//   TIMEOUT_CYCLES     64   watchdog limit (FEEDER_TIMEOUT_EN only)
// PORTS
//   clk             in   1           clock, rising edge
//   rst             in   1           asynchronous reset, active-high
//   start           in   1           begin one polynomial transfer (sampled in IDLE only)
//   tail_words      in   6           zero words appended after the real words; sampled on start
//   mem_rd_en       out  1           RAM read strobe
//   mem_addr        out  ADDR_WIDTH  RAM word address
//   mem_rdata       in   WORD_WIDTH  RAM data, valid 1 cycle after mem_rd_en
//   normal_word_in  out  WORD_WIDTH  word to round_block
//   word_valid      out  1           one-cycle word-issue pulse
//   only_add        out  1           1 = enqueue only, 0 = enqueue and process
//   word_accepted   in   1           round_block captured the word
//   processing_done in   1           round_block finished with the word
//   busy            out  1           transfer in progress
//   done            out  1           one-cycle pulse after the last word completes
//   word_index      out  ADDR_WIDTH+1 index of the word currently issued
//   timeout_err     out  1           sticky watchdog flag (tied 0 without FEEDER_TIMEOUT_EN)
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; counters 0.
//   FSM states: IDLE, FETCH, WAIT_DATA, SEND, WAIT_ACK, DONE.
//   IDLE:
//     - start=1: latch total = NORMAL_WORD_COUNT + tail_words; set index=0 and busy=1.
//     - Go to FETCH.
//   FETCH:
//     - index < NORMAL_WORD_COUNT: mem_rd_en=1 for one cycle, mem_addr=index; go to WAIT_DATA.
//     - Otherwise: no read; load word 0; go to SEND.
//   WAIT_DATA: register mem_rdata into normal_word_in; go to SEND.
//   SEND:
//     - word_valid=1 for exactly one cycle.
//     - only_add = (index < PRELOAD_COUNT).
//     - Go to WAIT_ACK.
//   WAIT_ACK:
//     - normal_word_in and only_add stay stable.
//     - word_valid stays 0, so round_block cannot re-sample the word.
//     - On processing_done=1: index++.
//     - If index+1 == total, go to DONE; else go to FETCH.
//     - word_accepted is monitored only; processing_done alone closes the handshake.
//       It arrives with word_accepted when only_add=1, and 1 cycle later otherwise.
//   DONE: done=1 for one cycle; busy=0; go to IDLE.
//   Word pacing: at most one word in flight; the next issue comes at least 2 cycles
//     after processing_done.
//   Boundaries:
//     - start while busy: ignored.
//     - tail_words=0: exactly NORMAL_WORD_COUNT words sent.
//     - tail_words=63: 616 words sent.
//     - Zero tail words never touch RAM (mem_rd_en stays 0).
//     - processing_done outside WAIT_ACK: ignored.
//     - processing_done in the same cycle as start: start is still honoured.
//     - rst asserted mid-transfer: return to IDLE immediately, outputs 0, no done pulse.
//   Arithmetic:
//     - index and total are ADDR_WIDTH+1 bits, so no wrap at 616.
//     - mem_addr = index[ADDR_WIDTH-1:0].
// CONFIGURATION
//   FEEDER_TIMEOUT_EN defined:
//     - A counter runs in WAIT_ACK and clears on entry.
//     - If it reaches TIMEOUT_CYCLES without processing_done: set timeout_err (sticky,
//       cleared only by rst), busy=0, go to IDLE with no done pulse.
//   FEEDER_TIMEOUT_EN undefined:
//     - No counter; WAIT_ACK waits indefinitely; timeout_err constant 0.
// TESTING
//   1. start, tail_words=0, RAM[i]=i+1, round_block model -> 553 word_valid pulses;
//      word 0 sent with only_add=1, words 1..552 with only_add=0; done pulse once; busy drops.
//   2. tail_words=5 -> 558 words; words 553..557 are 0 with no mem_rd_en; done after the 558th
//      processing_done.
//   3. Responder delays processing_done by 10 cycles -> word_valid never re-asserts while waiting;
//      normal_word_in stable throughout.
//   4. start pulsed again at word 100 -> ignored; sequence completes with 553 words.
//   5. rst asserted at word 200 -> all outputs 0 next edge; a new start sends from word 0 (addr 0).
//   6. FEEDER_TIMEOUT_EN, responder silent -> timeout_err=1 after 64 cycles in WAIT_ACK; state IDLE;
//      no done pulse.

Source files
------------

// File: rtl/normal_word_feeder.sv
// normal_word_feeder
//   Transmit side of the normal-word interface into round_block. Reads the
//   normal polynomial from word RAM and issues one word per handshake. The
//   first PRELOAD_COUNT words go out add-only (only_add=1) and the remaining
//   real words go out add+process. Then tail_words zero words follow to flush
//   the low-word window. Only one word is in flight at a time.
//
//   Optional build macro: FEEDER_TIMEOUT_EN enables a WAIT_ACK watchdog. If
//   processing_done has not arrived after TIMEOUT_CYCLES cycles, the transfer
//   aborts to IDLE and the sticky timeout_err flag is set.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a transfer (sampled in IDLE only)
//   tail_words        number of zero words appended, sampled with start
//   mem_rd_en/addr    RAM read strobe and word address
//   mem_rdata         RAM data, valid one cycle after mem_rd_en
//   normal_word_in    word presented to round_block
//   word_valid        one-cycle word-issue pulse
//   only_add          1 = enqueue only, 0 = enqueue and process
//   word_accepted     round_block captured the word (monitored only)
//   processing_done   round_block finished with the word; closes the handshake
//   busy              transfer in progress
//   done              one-cycle pulse after the last word completes
//   word_index        index of the word currently issued
//   timeout_err       sticky watchdog flag (constant 0 without the macro)
module normal_word_feeder #(
  parameter int WORD_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 10,
  parameter int NORMAL_WORD_COUNT = 553,
  parameter int PRELOAD_COUNT     = 1,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            tail_words,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] normal_word_in,
  output logic                  word_valid,
  output logic                  only_add,
  input  logic                  word_accepted,
  input  logic                  processing_done,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_index,
  output logic                  timeout_err
);

  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [IW-1:0] NWC = IW'(NORMAL_WORD_COUNT);
  localparam logic [IW-1:0] PRE = IW'(PRELOAD_COUNT);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, SEND, WAIT_ACK, DONE
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   index;
  logic [IW-1:0]   total;
  logic [WORD_WIDTH-1:0] word_q;
  logic            real_word;
  logic            last_word;
  logic            expired;

  assign real_word = (index < NWC);
  assign last_word = ((index + IW'(1)) == total);

  // word_accepted is informational only; processing_done alone ends WAIT_ACK.
  logic unused_accept;
  assign unused_accept = word_accepted;

`ifdef FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // wait_cnt is 0 on the first WAIT_ACK cycle, so expiry lands on the
  // TIMEOUT_CYCLES-th cycle spent waiting.
  assign expired = (state == WAIT_ACK) && !processing_done &&
                   (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT_ACK) ? wait_cnt + CW'(1) : '0;
      if (expired)
        err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      index  <= '0;
      total  <= '0;
      word_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            index <= '0;
            total <= NWC + IW'(tail_words);
          end
        end
        FETCH: begin
          // Tail words never touch RAM; they are plain zeros.
          if (!real_word)
            word_q <= '0;
        end
        WAIT_DATA: word_q <= mem_rdata;
        WAIT_ACK: begin
          if (processing_done && !expired)
            index <= index + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = FETCH;
      FETCH:     state_nxt = real_word ? WAIT_DATA : SEND;
      WAIT_DATA: state_nxt = SEND;
      SEND:      state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (expired)
          state_nxt = IDLE;
        else if (processing_done)
          state_nxt = last_word ? DONE : FETCH;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Index only moves when leaving WAIT_ACK, so only_add and the word stay
  // stable for the whole handshake.
  assign mem_rd_en      = (state == FETCH) && real_word;
  assign mem_addr       = index[ADDR_WIDTH-1:0];
  assign normal_word_in = word_q;
  assign word_valid     = (state == SEND);
  assign only_add       = ((state == SEND) || (state == WAIT_ACK)) && (index < PRE);
  assign busy           = (state == FETCH) || (state == WAIT_DATA) ||
                          (state == SEND)  || (state == WAIT_ACK);
  assign done           = (state == DONE);
  assign word_index     = index;

endmodule

// File: tb/tb_normal_word_feeder.sv
module tb_normal_word_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  tail_words;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] normal_word_in;
  logic        word_valid;
  logic        only_add;
  logic        word_accepted;
  logic        processing_done;
  logic        busy;
  logic        done;
  logic [10:0] word_index;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  // Collected per transfer by run_xfer
  int n_words, n_rd, n_rd_tail, n_bad_addr, n_bad_data, n_bad_oa, n_bad_idx;
  int n_revalid, n_unstable, n_done, n_pace_bad;
  bit budget_hit;

  normal_word_feeder dut (
    .clk(clk), .rst(rst), .start(start), .tail_words(tail_words),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .normal_word_in(normal_word_in), .word_valid(word_valid), .only_add(only_add),
    .word_accepted(word_accepted), .processing_done(processing_done),
    .busy(busy), .done(done), .word_index(word_index), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // RAM model: RAM[i] = i+1, one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 32'(mem_addr) + 32'd1;
  end

  // Drives one transfer and acts as the round_block responder. Stops on done,
  // on issuing stop_at words, or when the cycle budget runs out.
  task automatic run_xfer(input int tail, input int delay, input int restart_at,
                          input int stop_at, input bit pd_with_start);
    int k = 0;
    int since_pd = 1000;
    bit waiting = 1'b0;
    logic [31:0] held_w = '0;
    logic [31:0] exp_w;
    logic held_oa = 1'b0;
    n_words = 0; n_rd = 0; n_rd_tail = 0; n_bad_addr = 0; n_bad_data = 0;
    n_bad_oa = 0; n_bad_idx = 0; n_revalid = 0; n_unstable = 0; n_done = 0;
    n_pace_bad = 0; budget_hit = 1'b1;
    @(negedge clk);
    tail_words = 6'(tail); start = 1'b1; processing_done = pd_with_start;
    word_accepted = 1'b0;
    @(negedge clk);
    start = 1'b0; processing_done = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      processing_done = 1'b0; word_accepted = 1'b0; start = 1'b0;
      since_pd++;
      if (mem_rd_en) begin
        n_rd++;
        if (n_words >= 553) n_rd_tail++;
        if (mem_addr !== 10'(n_words)) n_bad_addr++;
      end
      if (done) begin
        n_done++;
        budget_hit = 1'b0;
        break;
      end
      if (word_valid) begin
        if (waiting) n_revalid++;
        if (since_pd < 2) n_pace_bad++;
        exp_w = (n_words < 553) ? 32'(n_words + 1) : 32'd0;
        if (normal_word_in !== exp_w) n_bad_data++;
        if (only_add !== (n_words < 1)) n_bad_oa++;
        if (word_index !== 11'(n_words)) n_bad_idx++;
        held_w = normal_word_in; held_oa = only_add;
        waiting = 1'b1; k = 0;
        if (n_words == restart_at) start = 1'b1;
        n_words++;
        if (n_words == stop_at) begin
          budget_hit = 1'b0;
          break;
        end
      end else if (waiting) begin
        k++;
        if (normal_word_in !== held_w || only_add !== held_oa) n_unstable++;
        if (k == 1 + delay) word_accepted = 1'b1;
        if (k == (held_oa ? 1 + delay : 2 + delay)) begin
          processing_done = 1'b1; waiting = 1'b0; since_pd = 0;
        end
      end
      @(negedge clk);
    end
    processing_done = 1'b0; word_accepted = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tail_words = '0; processing_done = 1'b0;
    word_accepted = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, word_valid, mem_rd_en, only_add, timeout_err} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, word_valid, mem_rd_en, only_add, timeout_err}); end
    checks++; if (normal_word_in !== 32'd0) begin failures++; $display("FAIL reset_word got=%0d exp=0", normal_word_in); end
    checks++; if (word_index !== 11'd0 || mem_addr !== 10'd0) begin failures++; $display("FAIL reset_index got=%0d/%0d exp=0/0", word_index, mem_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_xfer(0, 0, -1, -1, 1'b0);
    checks++; if (budget_hit) begin failures++; $display("FAIL basic_budget got=timeout exp=done"); end
    checks++; if (n_words !== 553) begin failures++; $display("FAIL basic_words got=%0d exp=553", n_words); end
    checks++; if (n_bad_data !== 0) begin failures++; $display("FAIL basic_data got=%0d bad exp=0", n_bad_data); end
    checks++; if (n_bad_oa !== 0) begin failures++; $display("FAIL basic_only_add got=%0d bad exp=0", n_bad_oa); end
    checks++; if (n_bad_idx !== 0 || n_bad_addr !== 0) begin failures++; $display("FAIL basic_index got=%0d/%0d bad exp=0/0", n_bad_idx, n_bad_addr); end
    checks++; if (n_rd !== 553) begin failures++; $display("FAIL basic_reads got=%0d exp=553", n_rd); end
    checks++; if (n_pace_bad !== 0) begin failures++; $display("FAIL basic_pacing got=%0d bad exp=0", n_pace_bad); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", n_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_after_done got=%b%b exp=00", done, busy); end
  endtask

  task automatic test_tail();
    // processing_done together with start must not block the start
    run_xfer(5, 0, -1, -1, 1'b1);
    checks++; if (n_words !== 558) begin failures++; $display("FAIL tail5_words got=%0d exp=558", n_words); end
    checks++; if (n_rd !== 553 || n_rd_tail !== 0) begin failures++; $display("FAIL tail5_reads got=%0d/%0d exp=553/0", n_rd, n_rd_tail); end
    checks++; if (n_bad_data !== 0 || n_bad_idx !== 0) begin failures++; $display("FAIL tail5_data got=%0d/%0d bad exp=0/0", n_bad_data, n_bad_idx); end
    checks++; if (n_done !== 1 || n_pace_bad !== 0) begin failures++; $display("FAIL tail5_done got=%0d/%0d exp=1/0", n_done, n_pace_bad); end
    run_xfer(63, 0, -1, -1, 1'b0);
    checks++; if (n_words !== 616) begin failures++; $display("FAIL tail63_words got=%0d exp=616", n_words); end
    checks++; if (n_rd !== 553 || n_bad_idx !== 0 || n_bad_data !== 0) begin failures++; $display("FAIL tail63_stream got=%0d/%0d/%0d exp=553/0/0", n_rd, n_bad_idx, n_bad_data); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL tail63_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_slow_responder();
    run_xfer(0, 10, -1, -1, 1'b0);
    checks++; if (n_revalid !== 0) begin failures++; $display("FAIL slow_revalid got=%0d exp=0", n_revalid); end
    checks++; if (n_unstable !== 0) begin failures++; $display("FAIL slow_stable got=%0d exp=0", n_unstable); end
    checks++; if (n_words !== 553 || n_done !== 1) begin failures++; $display("FAIL slow_words got=%0d/%0d exp=553/1", n_words, n_done); end
  endtask

  task automatic test_restart_ignored();
    run_xfer(0, 0, 100, -1, 1'b0);
    checks++; if (n_words !== 553 || n_done !== 1) begin failures++; $display("FAIL restart_words got=%0d/%0d exp=553/1", n_words, n_done); end
    checks++; if (n_bad_data !== 0 || n_bad_idx !== 0) begin failures++; $display("FAIL restart_data got=%0d/%0d bad exp=0/0", n_bad_data, n_bad_idx); end
  endtask

  task automatic test_mid_reset();
    run_xfer(0, 0, -1, 201, 1'b0);
    checks++; if (n_words !== 201) begin failures++; $display("FAIL midrst_reach got=%0d exp=201", n_words); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, word_valid, mem_rd_en, only_add} !== 5'b0) begin failures++; $display("FAIL midrst_flags got=%b exp=00000", {busy, done, word_valid, mem_rd_en, only_add}); end
    checks++; if (normal_word_in !== 32'd0 || word_index !== 11'd0) begin failures++; $display("FAIL midrst_data got=%0d/%0d exp=0/0", normal_word_in, word_index); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_nodone got=%b exp=0", done); end
    rst = 1'b0;
    run_xfer(0, 0, -1, -1, 1'b0);
    checks++; if (n_words !== 553 || n_bad_addr !== 0 || n_bad_data !== 0) begin failures++; $display("FAIL midrst_rerun got=%0d/%0d/%0d exp=553/0/0", n_words, n_bad_addr, n_bad_data); end
  endtask

  task automatic test_silent_responder();
    int dones = 0;
    int valids = 0;
    @(negedge clk);
    tail_words = 6'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) dones++;
      if (word_valid) valids++;
      @(negedge clk);
    end
    checks++; if (dones !== 0 || valids !== 1) begin failures++; $display("FAIL silent_pulses got=%0d/%0d exp=0/1", dones, valids); end
`ifdef FEEDER_TIMEOUT_EN
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL silent_timeout got=%b%b exp=10", timeout_err, busy); end
`else
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL silent_wait got=%b%b exp=01", timeout_err, busy); end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL silent_rst got=%b%b exp=00", timeout_err, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail();
    test_slow_responder();
    test_restart_ignored();
    test_mid_reset();
    test_silent_responder();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
